// File: rtl/fifo_pkg.sv
// Shared constants and a width helper for the parameterised FIFO family.
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Bits needed to hold values 0..value-1 (ceil(log2(value))), minimum 1.
    function automatic int unsigned clog2_width(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its user.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) ();

    logic             we;
    logic [WIDTH-1:0] din;
    logic             re;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             rvalid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [DEPTH:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output we, din, re, clr_err,
        input  dout, rvalid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  we, din, re, clr_err,
        output dout, rvalid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port (async or registered read).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter bit          SYNC_READ = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned SIZE = 2 ** DEPTH;

    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (SYNC_READ) begin : g_sync
            // Read-before-write: a same-edge write to raddr returns the old word.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async
            logic unused_ctl;
            assign unused_ctl = &{1'b0, re, reset};
            assign rdata      = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO control: pointers, occupancy, registered status and sticky errors.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned FWFT     = 1,
    parameter int unsigned AF_LEVEL = (2 ** DEPTH) - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         reset,
    param_fifo_if.slave  bus
);

    localparam int unsigned SIZE  = 2 ** DEPTH;
    localparam int unsigned CNT_W = clog2_width(SIZE + 1);

    logic [DEPTH-1:0] head;
    logic [DEPTH-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_ok;
    logic             rd_ok;
    logic             ov_evt;
    logic             un_evt;
    logic             empty_q;
    logic             full_q;
    logic             ae_q;
    logic             af_q;
    logic             ov_q;
    logic             un_q;
    logic             rvalid_q;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        rd_ok     = bus.re && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_ok     = bus.we && ((count_q != CNT_W'(SIZE)) || rd_ok);
        ov_evt    = bus.we && !wr_ok;
        un_evt    = bus.re && !rd_ok && !wr_ok;
        count_nxt = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_ok) head <= head + 1'b1;
            if (rd_ok) tail <= tail + 1'b1;
            count_q  <= count_nxt;
            empty_q  <= (count_nxt == '0);
            full_q   <= (count_nxt == CNT_W'(SIZE));
            ae_q     <= (32'(count_nxt) <= AE_LEVEL);
            af_q     <= (32'(count_nxt) >= AF_LEVEL);
            ov_q     <= ov_evt ? 1'b1 : (bus.clr_err ? 1'b0 : ov_q);
            un_q     <= un_evt ? 1'b1 : (bus.clr_err ? 1'b0 : un_q);
            rvalid_q <= rd_ok;
        end
    end

    fifo_ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .SYNC_READ (FWFT == 0)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (head),
        .wdata (bus.din),
        .re    (rd_ok),
        .raddr (tail),
        .rdata (rdata)
    );

    assign bus.dout         = rdata;
    assign bus.rvalid       = (FWFT != 0) ? !empty_q : rvalid_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ov_q;
    assign bus.underflow    = un_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: FWFT and registered-read builds at DEPTH=2 against a queue model.
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        t_we = 1'b0;
    logic        t_re = 1'b0;
    logic        t_clr = 1'b0;
    logic [15:0] t_din = '0;

    int          tests = 0;
    int          failed = 0;
    bit          checking = 1'b0;

    logic [15:0] q[$];
    logic        m_ov, m_un, m_rv_b;
    logic [15:0] m_dout_b;
    int          n;

    always #5 clk = ~clk;

    param_fifo_if #(.WIDTH(16), .DEPTH(2)) bus_a ();
    param_fifo_if #(.WIDTH(16), .DEPTH(2)) bus_b ();

    assign bus_a.we = t_we;  assign bus_a.re = t_re;  assign bus_a.din = t_din;  assign bus_a.clr_err = t_clr;
    assign bus_b.we = t_we;  assign bus_b.re = t_re;  assign bus_b.din = t_din;  assign bus_b.clr_err = t_clr;

    param_fifo #(.WIDTH(16), .DEPTH(2), .FWFT(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    param_fifo #(.WIDTH(16), .DEPTH(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov     = 1'b0;
        m_un     = 1'b0;
        m_rv_b   = 1'b0;
        m_dout_b = '0;
    endtask

    // One clock of stimulus; model advances from the pre-edge state and inputs.
    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
        int          sz;
        logic        rd, wr;
        t_we = w; t_din = d; t_re = r; t_clr = c;
        sz = q.size();
        rd = r && (sz > 0);
        wr = w && ((sz < 4) || rd);
        @(posedge clk);
        #1;
        if (rd) m_dout_b = q.pop_front();
        if (wr) q.push_back(d);
        m_rv_b = rd;
        m_ov = (w && !wr) ? 1'b1 : (c ? 1'b0 : m_ov);
        m_un = (r && !rd && !wr) ? 1'b1 : (c ? 1'b0 : m_un);
        t_we = 1'b0; t_re = 1'b0; t_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            n = q.size();
            chk("count_a", 32'(bus_a.count), n);
            chk("count_b", 32'(bus_b.count), n);
            chk("empty_a", 32'(bus_a.empty), 32'(n == 0));
            chk("empty_b", 32'(bus_b.empty), 32'(n == 0));
            chk("full_a", 32'(bus_a.full), 32'(n == 4));
            chk("full_b", 32'(bus_b.full), 32'(n == 4));
            chk("af_a", 32'(bus_a.almost_full), 32'(n >= 2));
            chk("ae_a", 32'(bus_a.almost_empty), 32'(n <= 2));
            chk("af_b", 32'(bus_b.almost_full), 32'(n >= 3));
            chk("ae_b", 32'(bus_b.almost_empty), 32'(n <= 1));
            chk("ovf_a", 32'(bus_a.overflow), 32'(m_ov));
            chk("ovf_b", 32'(bus_b.overflow), 32'(m_ov));
            chk("unf_a", 32'(bus_a.underflow), 32'(m_un));
            chk("unf_b", 32'(bus_b.underflow), 32'(m_un));
            chk("rvalid_a", 32'(bus_a.rvalid), 32'(n != 0));
            if (n != 0) chk("dout_a", 32'(bus_a.dout), 32'(q[0]));
            chk("rvalid_b", 32'(bus_b.rvalid), 32'(m_rv_b));
            chk("dout_b", 32'(bus_b.dout), 32'(m_dout_b));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lits[4];
        lits[0] = 16'h0A0A; lits[1] = 16'h0B0B; lits[2] = 16'h0C0C; lits[3] = 16'h0D0D;
        model_reset();

        #2 reset = 1'b0;
        #2;
        chk("rst_empty_a", 32'(bus_a.empty), 32'd1);
        chk("rst_ae_b", 32'(bus_b.almost_empty), 32'd1);
        chk("rst_count_a", 32'(bus_a.count), 32'd0);
        chk("rst_full_a", 32'(bus_a.full), 32'd0);
        chk("rst_af_a", 32'(bus_a.almost_full), 32'd0);
        chk("rst_rvalid_b", 32'(bus_b.rvalid), 32'd0);
        chk("rst_dout_b", 32'(bus_b.dout), 32'd0);
        chk("rst_ovf_b", 32'(bus_b.overflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        checking = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 4; i++) step(1'b1, lits[i], 1'b0, 1'b0);
        chk("fill_count", 32'(bus_a.count), 32'd4);
        chk("fill_full", 32'(bus_a.full), 32'd1);
        chk("fill_af", 32'(bus_a.almost_full), 32'd1);
        step(1'b1, 16'h0E0E, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus_a.overflow), 32'd1);
        chk("ovf_count", 32'(bus_b.count), 32'd4);

        // Drain in order, then underflow and clear.
        for (int i = 0; i < 4; i++) begin
            chk("order_a", 32'(bus_a.dout), 32'(lits[i]));
            step(1'b0, '0, 1'b1, 1'b0);
            chk("order_b", 32'(bus_b.dout), 32'(lits[i]));
        end
        chk("drain_empty", 32'(bus_a.empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set", 32'(bus_a.underflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(bus_a.overflow), 32'd0);
        chk("clr_unf", 32'(bus_a.underflow), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("set_wins", 32'(bus_b.underflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 4; i++) step(1'b1, lits[i], 1'b0, 1'b0);
        step(1'b1, 16'h0E0E, 1'b1, 1'b0);
        chk("rw_full_count", 32'(bus_a.count), 32'd4);
        chk("rw_full_ovf", 32'(bus_a.overflow), 32'd0);
        chk("rw_full_head", 32'(bus_a.dout), 32'h0B0B);
        chk("rd_lat_rvalid", 32'(bus_b.rvalid), 32'd1);
        chk("rd_lat_dout", 32'(bus_b.dout), 32'h0A0A);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rd_lat_drop", 32'(bus_b.rvalid), 32'd0);
        chk("rd_lat_hold", 32'(bus_b.dout), 32'h0A0A);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Empty with simultaneous read and write: no bypass.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("rw_empty_count", 32'(bus_a.count), 32'd1);
        chk("rw_empty_unf", 32'(bus_a.underflow), 32'd0);
        chk("rw_empty_dout", 32'(bus_a.dout), 32'h1234);
        step(1'b0, '0, 1'b1, 1'b0);

        // Pointer wrap traffic.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 16'(i * 16 + k + 16'h0100), 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));

        // Asynchronous reset in the middle of a burst.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h5500 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h55AA, 1'b1, 1'b0);
        #2;
        checking = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_empty_a", 32'(bus_a.empty), 32'd1);
        chk("async_empty_b", 32'(bus_b.empty), 32'd1);
        chk("async_count_b", 32'(bus_b.count), 32'd0);
        chk("async_rvalid_b", 32'(bus_b.rvalid), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        checking = 1'b1;
        step(1'b1, 16'h7777, 1'b0, 1'b0);
        chk("post_rst_write", 32'(bus_a.dout), 32'h7777);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        @(posedge clk);
        #1 checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 8, log2 of entry count; FIFO_SIZE = 2**DEPTH, legal DEPTH 1..12.
REQ-003 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered read with one-cycle latency.
REQ-004 SHALL have parameter AF_LEVEL, default FIFO_SIZE-2, the almost-full threshold; parameter AE_LEVEL, default 2, the almost-empty threshold.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  write request; din  in  WIDTH  write data.
REQ-008 re  in  1  read request.
REQ-009 dout  out  WIDTH  read data; rvalid  out  1  dout qualifier.
REQ-010 empty, full, almost_empty, almost_full  out  1 each  status flags.
REQ-011 count  out  DEPTH+1  current occupancy, 0..FIFO_SIZE.
REQ-012 overflow, underflow  out  1 each  sticky error flags; clr_err  in  1  synchronous clear of both.

Function
REQ-013 Write accepted iff we=1 and (count<FIFO_SIZE or read accepted same cycle); accepted word stored at head, head advances modulo FIFO_SIZE.
REQ-014 Read accepted iff re=1 and count>0; tail advances modulo FIFO_SIZE.
REQ-015 Simultaneous accepted read and write: count unchanged; when full, write of new word and pop of oldest both occur.
REQ-016 Write to empty FIFO with re=1 same cycle: write accepted, read rejected (no bypass).
REQ-017 count, empty, full, almost_* SHALL be registered, reflecting state after the current edge's accepted operations.
REQ-018 empty = (count==0); full = (count==FIFO_SIZE); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL).
REQ-019 FWFT=1: dout = mem[tail] combinationally, rvalid = !empty; re acknowledges the displayed word.
REQ-020 FWFT=0: on accepted read, dout registers mem[tail] and rvalid pulses 1 on the following cycle; dout holds otherwise.
REQ-021 Rejected write (we=1, full, no concurrent read) SHALL set overflow; memory and pointers unchanged.
REQ-022 Rejected read (re=1, empty) SHALL set underflow; state unchanged.
REQ-023 overflow/underflow remain 1 until clr_err=1 or reset; an error event coincident with clr_err sets the flag (set wins).
REQ-024 Pointers DEPTH bits wide; occupancy tracked in DEPTH+1-bit counter, no looped flag.

Reset
REQ-025 reset=0 SHALL immediately clear head, tail, count, rvalid, overflow, underflow, full, almost_full; set empty=1, almost_empty=1; dout=0 in FWFT=0 mode.
REQ-026 Memory contents are not reset; reset mid-operation discards all stored words.
REQ-027 Deassertion is synchronised externally; first accepted write is permitted on the first edge after deassertion.

Structure
REQ-028 Package fifo_pkg SHALL hold shared constants: default WIDTH/DEPTH and a clog2-style width helper.
REQ-029 Storage SHALL be sub-module fifo_ram (1 write port, 1 read port, async read for FWFT=1, sync read for FWFT=0); control logic in param_fifo.

Verification
REQ-030 DEPTH=2, write 4 words A..D -> full=1, count=4, almost_full=1; 5th write -> overflow=1, count stays 4.
REQ-031 Read 4 words from REQ-030 -> order A,B,C,D, empty=1; further re -> underflow=1; clr_err -> both flags 0.
REQ-032 Full FIFO, we=re=1 with din=E -> A popped, E stored, count stays 4, no overflow.
REQ-033 Empty FIFO, we=re=1 -> count=1, no underflow, word readable next cycle.
REQ-034 10 wraps of 3-in/3-out traffic at DEPTH=2 -> data order preserved, count never exceeds 4.
REQ-035 FWFT=0 build: accepted read at cycle N -> rvalid=1 with correct dout at cycle N+1; reset=0 mid-burst -> empty=1, count=0 asynchronously.
